nand_io_burst: RTL

Parametrised NAND data-bus IO engine. It succeeds the single-word IO unit with a configurable data width, runtime-programmable strobe timing, multi-word bursts, a host-side valid/ready write handshake, 8-bit/16-bit bus mode and abort. It sits between the controller's command sequencer and the NAND pad ring, and drives the RE#/WE# strobe through `io_ctrl`.

---
 rtl/nand_io_burst.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/nand_io_burst.sv
// NAND data-bus IO engine: programmable-timing RE#/WE# strobes, multi-word bursts,
// host write handshake, 8/16-bit bus mode and abort.
module nand_io_burst #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 12,
    parameter int DLY_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              activate,
    input  logic              io_type,
    input  logic [CNT_W-1:0]  burst_len,
    input  logic [DLY_W-1:0]  t_low,
    input  logic [DLY_W-1:0]  t_high,
    input  logic              wide,
    input  logic              abort,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              bus_oe,
    output logic              io_ctrl,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, FETCH, LOW, HIGH} state_t;

    // On an 8-bit build this mask is all ones, so narrow mode has no effect.
    localparam logic [DATA_W-1:0] LO_MASK = DATA_W'(8'hFF);

    function automatic logic [DATA_W-1:0] bus_mask(input logic [DATA_W-1:0] w,
                                                   input logic wd);
        return wd ? w : (w & LO_MASK);
    endfunction

    function automatic logic [DLY_W-1:0] dly_sat(input logic [DLY_W-1:0] v);
        return (v == '0) ? DLY_W'(1) : v;
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DLY_W-1:0]   dly_q, dly_d;
    logic [DLY_W-1:0]   tl_q, tl_d, th_q, th_d;
    logic               is_rd_q, is_rd_d, wide_q, wide_d;
    logic [DATA_W-1:0]  rd_data_d, data_out_d;
    logic               wr_ready_d, rd_valid_d, bus_oe_d, io_ctrl_d, busy_d, done_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dly_d      = dly_q;
        tl_d       = tl_q;
        th_d       = th_q;
        is_rd_d    = is_rd_q;
        wide_d     = wide_q;
        rd_data_d  = rd_data;
        data_out_d = data_out;
        wr_ready_d = 1'b0;
        rd_valid_d = 1'b0;
        bus_oe_d   = bus_oe;
        io_ctrl_d  = io_ctrl;
        busy_d     = busy;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (activate) begin
                    tl_d    = dly_sat(t_low);
                    th_d    = dly_sat(t_high);
                    is_rd_d = io_type;
                    wide_d  = wide;
                    cnt_d   = (burst_len == '0) ? CNT_W'(1) : burst_len;
                    busy_d  = 1'b1;
                    if (io_type) begin
                        state_d   = LOW;
                        io_ctrl_d = 1'b0;
                        dly_d     = dly_sat(t_low) - DLY_W'(1);
                    end else begin
                        state_d    = FETCH;
                        wr_ready_d = 1'b1;
                    end
                end
            end
            FETCH: begin
                wr_ready_d = 1'b1;
                if (wr_valid && wr_ready) begin
                    data_out_d = bus_mask(wr_data, wide_q);
                    bus_oe_d   = 1'b1;
                    wr_ready_d = 1'b0;
                    state_d    = LOW;
                    io_ctrl_d  = 1'b0;
                    dly_d      = tl_q - DLY_W'(1);
                end
            end
            LOW: begin
                if (dly_q == '0) begin
                    state_d   = HIGH;
                    io_ctrl_d = 1'b1;
                    dly_d     = th_q - DLY_W'(1);
                    if (is_rd_q) begin
                        rd_data_d  = bus_mask(data_in, wide_q);
                        rd_valid_d = 1'b1;
                    end
                end else begin
                    dly_d = dly_q - DLY_W'(1);
                end
            end
            HIGH: begin
                if (dly_q == '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d    = IDLE;
                        done_d     = 1'b1;
                        busy_d     = 1'b0;
                        bus_oe_d   = 1'b0;
                        data_out_d = '0;
                    end else if (is_rd_q) begin
                        state_d   = LOW;
                        io_ctrl_d = 1'b0;
                        dly_d     = tl_q - DLY_W'(1);
                    end else begin
                        state_d    = FETCH;
                        wr_ready_d = 1'b1;
                    end
                end else begin
                    dly_d = dly_q - DLY_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides whatever the state logic decided, including a capture.
        if (abort && (state_q != IDLE)) begin
            state_d    = IDLE;
            io_ctrl_d  = 1'b1;
            bus_oe_d   = 1'b0;
            wr_ready_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            rd_valid_d = 1'b0;
            rd_data_d  = rd_data;
            data_out_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            dly_q    <= '0;
            tl_q     <= '0;
            th_q     <= '0;
            is_rd_q  <= 1'b0;
            wide_q   <= 1'b0;
            rd_data  <= '0;
            data_out <= '0;
            wr_ready <= 1'b0;
            rd_valid <= 1'b0;
            bus_oe   <= 1'b0;
            io_ctrl  <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dly_q    <= dly_d;
            tl_q     <= tl_d;
            th_q     <= th_d;
            is_rd_q  <= is_rd_d;
            wide_q   <= wide_d;
            rd_data  <= rd_data_d;
            data_out <= data_out_d;
            wr_ready <= wr_ready_d;
            rd_valid <= rd_valid_d;
            bus_oe   <= bus_oe_d;
            io_ctrl  <= io_ctrl_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

endmodule
